// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters, zero-latency lookup,
// EX-stage training, mispredict detection and saturating performance counters.
module branch_target_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_flush_all,
    input  logic            i_upd_valid,
    input  logic            i_upd_is_jump,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_pred_taken,
    input  logic [XLEN-1:0] i_upd_pred_target,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag     [ENTRIES];
    logic [XLEN-1:0]    r_target  [ENTRIES];
    logic               r_is_jump [ENTRIES];
    logic [CTR_W-1:0]   r_ctr     [ENTRIES];
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_mispred_count;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_write;
    logic [CTR_W-1:0] w_ctr_cur;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic             w_unused;

    assign w_lk_idx = i_if_pc[IDX_W+1:2];
    assign w_lk_tag = i_if_pc[XLEN-1:IDX_W+2];
    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
    assign w_unused = ^{i_if_pc[1:0], i_upd_pc[1:0]};

    // Lookup reads pre-edge storage, so a same-cycle update shows up one cycle later.
    assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_pred_taken  = w_lk_hit && (r_is_jump[w_lk_idx] || r_ctr[w_lk_idx][CTR_W-1]);
    assign o_pred_target = o_pred_taken ? r_target[w_lk_idx] : i_if_pc + XLEN'(4);

    assign o_mispredict  = i_upd_valid && ((i_upd_taken != i_upd_pred_taken) ||
                           (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + XLEN'(4);

    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_write = i_upd_valid && (w_up_hit || i_upd_taken);
    assign w_ctr_cur  = r_ctr[w_up_idx];

    always_comb begin
        w_ctr_nxt = w_ctr_cur;
        if (!w_up_hit || i_upd_is_jump) begin
            w_ctr_nxt = i_upd_is_jump ? CTR_MAX : CTR_WEAK;
        end else if (i_upd_taken) begin
            if (w_ctr_cur != CTR_MAX) w_ctr_nxt = w_ctr_cur + CTR_W'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid         <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) r_ctr[i] <= '0;
        end else begin
            if (i_upd_valid && (r_br_count != '1)) r_br_count <= r_br_count + CNT_W'(1);
            if (o_mispredict && (r_mispred_count != '1)) begin
                r_mispred_count <= r_mispred_count + CNT_W'(1);
            end
            if (i_flush_all) begin
                r_valid <= '0;
                for (int i = 0; i < int'(ENTRIES); i++) r_ctr[i] <= '0;
            end else if (w_up_write) begin
                r_ctr[w_up_idx] <= w_ctr_nxt;
                if (i_upd_taken || i_upd_is_jump) r_target[w_up_idx] <= i_upd_target;
                if (!w_up_hit) begin
                    r_valid[w_up_idx]   <= 1'b1;
                    r_tag[w_up_idx]     <= w_up_tag;
                    r_is_jump[w_up_idx] <= i_upd_is_jump;
                end
            end
        end
    end

    assign o_br_count      = r_br_count;
    assign o_mispred_count = r_mispred_count;

endmodule
